regfile_write_scheduler: RTL

Sits in front of the 32x32 register file (two async read ports, one write port sampled on negedge clk) and owns its single write port. It arbitrates that port between the fixed-latency pipeline writeback (WB) and the variable-latency mult/div unit (MD). MD results wait in a one-entry holding buffer. A per-register scoreboard of outstanding MD destinations stalls the issue stage on RAW/WAW hazards and when the MD in-flight limit is reached.

---
 rtl/regfile_write_scheduler_pkg.sv | 23 ++
 rtl/regfile_write_scheduler_if.sv | 42 ++++
 rtl/regfile_write_scheduler_scoreboard.sv | 69 ++++++
 rtl/regfile_write_scheduler.sv | 99 +++++++++
 4 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared widths, constants and helpers for the register-file write scheduler.
package regfile_write_scheduler_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // One pending write: destination register and its data.
    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

    // One-hot mask over registers 1..31; register 0 has no bit.
    function automatic logic [NUM_REGS-1:1] reg_onehot(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] full;
        full = NUM_REGS'(1) << r;
        return full[NUM_REGS-1:1];
    endfunction

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Issue, writeback, mult/div and register-file write signals of the scheduler.
interface regfile_write_scheduler_if;
    import regfile_write_scheduler_pkg::*;

    logic              issue_valid;
    logic [REG_W-1:0]  issue_rs;
    logic [REG_W-1:0]  issue_rt;
    logic [REG_W-1:0]  issue_dst;
    logic              issue_long;
    logic              issue_stall;

    logic              wb_valid;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;

    logic              md_valid;
    logic [REG_W-1:0]  md_reg;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;

    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              sb_err;

    // Pipeline side: drives issue, WB and MD requests.
    modport master (
        output issue_valid, issue_rs, issue_rt, issue_dst, issue_long,
        output wb_valid, wb_reg, wb_data,
        output md_valid, md_reg, md_data,
        input  issue_stall, md_ready, rf_we, rf_waddr, rf_wdata, sb_err
    );

    // Scheduler side.
    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_dst, issue_long,
        input  wb_valid, wb_reg, wb_data,
        input  md_valid, md_reg, md_data,
        output issue_stall, md_ready, rf_we, rf_waddr, rf_wdata, sb_err
    );

endinterface

// File: rtl/regfile_write_scheduler_scoreboard.sv
// Tracks registers awaiting a mult/div result and decides issue stalls.
module regfile_scoreboard
    import regfile_write_scheduler_pkg::*;
#(
    parameter int LONG_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_issue_valid,
    input  logic [REG_W-1:0] i_issue_rs,
    input  logic [REG_W-1:0] i_issue_rt,
    input  logic [REG_W-1:0] i_issue_dst,
    input  logic             i_issue_long,
    input  logic             i_starve_stall,
    input  logic             i_commit,
    input  logic [REG_W-1:0] i_commit_reg,
    output logic             o_issue_stall,
    output logic             o_commit_pending
);

    logic [NUM_REGS-1:1] r_pending;
    logic [2:0]          r_long_cnt;

    logic [NUM_REGS-1:0] w_pend_full;
    logic                w_raw;
    logic                w_waw;
    logic                w_depth_full;
    logic                w_set;
    logic                w_clr;
    logic [NUM_REGS-1:1] w_set_mask;
    logic [NUM_REGS-1:1] w_clr_mask;

    // Register 0 reads as never pending.
    assign w_pend_full  = {r_pending, 1'b0};

    assign w_raw        = w_pend_full[i_issue_rs] | w_pend_full[i_issue_rt];
    assign w_waw        = w_pend_full[i_issue_dst];
    assign w_depth_full = i_issue_long && (r_long_cnt == 3'(LONG_DEPTH));

    assign o_issue_stall = i_issue_valid &&
                           (w_raw || w_waw || w_depth_full || i_starve_stall);

    assign w_set = i_issue_valid && !o_issue_stall && i_issue_long &&
                   (i_issue_dst != REG_ZERO);

    // A commit to a register that was never marked pending is an error case;
    // it must not release a slot it never held, so the count only drops on
    // commits that actually clear a pending bit.
    assign o_commit_pending = w_pend_full[i_commit_reg];
    assign w_clr            = i_commit && o_commit_pending;

    assign w_set_mask = w_set ? reg_onehot(i_issue_dst)  : '0;
    assign w_clr_mask = w_clr ? reg_onehot(i_commit_reg) : '0;

    // Pending vector and in-flight count; set wins over clear on the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_long_cnt <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
            if (w_set && !w_clr)
                r_long_cnt <= r_long_cnt + 3'd1;
            else if (w_clr && !w_set)
                r_long_cnt <= r_long_cnt - 3'd1;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register-file write port: WB first, buffered mult/div results when
// WB is idle, with starvation protection and a scoreboard-driven issue stall.
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int LONG_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    regfile_write_scheduler_if.slave  bus
);

    rf_wr_t            r_buf;
    logic              r_buf_valid;
    logic [3:0]        r_starve_cnt;
    logic              r_sb_err;

    logic              w_buf_commit;
    logic              w_md_ready;
    logic              w_capture;
    logic              w_starve_stall;
    logic              w_commit_pending;
    logic              w_issue_stall;
    logic [REG_W-1:0]  w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    assign w_buf_commit   = r_buf_valid && !bus.wb_valid;
    assign w_md_ready     = !r_buf_valid || w_buf_commit;
    assign w_capture      = bus.md_valid && w_md_ready;
    assign w_starve_stall = (r_starve_cnt == 4'(STARVE_LIMIT));

    // Write-port mux: WB always wins, otherwise the buffered MD result.
    always_comb begin
        w_wr_addr = r_buf.addr;
        w_wr_data = r_buf.data;
        if (bus.wb_valid) begin
            w_wr_addr = bus.wb_reg;
            w_wr_data = bus.wb_data;
        end
    end

    assign bus.rf_we       = (bus.wb_valid || r_buf_valid) && (w_wr_addr != REG_ZERO);
    assign bus.rf_waddr    = w_wr_addr;
    assign bus.rf_wdata    = w_wr_data;
    assign bus.md_ready    = w_md_ready;
    assign bus.issue_stall = w_issue_stall;
    assign bus.sb_err      = r_sb_err;

    // One-entry MD holding buffer; a capture in a commit cycle refills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf       <= '0;
        end else if (w_capture) begin
            r_buf_valid <= 1'b1;
            r_buf.addr  <= bus.md_reg;
            r_buf.data  <= bus.md_data;
        end else if (w_buf_commit) begin
            r_buf_valid <= 1'b0;
        end
    end

    // Counts cycles a full buffer loses the port to WB, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_starve_cnt <= '0;
        else if (w_buf_commit)
            r_starve_cnt <= '0;
        else if (r_buf_valid && bus.wb_valid && !w_starve_stall)
            r_starve_cnt <= r_starve_cnt + 4'd1;
    end

    // Sticky flag for an MD result landing on a register nobody was waiting on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sb_err <= 1'b0;
        else if (w_buf_commit && (r_buf.addr != REG_ZERO) && !w_commit_pending)
            r_sb_err <= 1'b1;
    end

    regfile_scoreboard #(
        .LONG_DEPTH (LONG_DEPTH)
    ) u_scoreboard (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_issue_valid    (bus.issue_valid),
        .i_issue_rs       (bus.issue_rs),
        .i_issue_rt       (bus.issue_rt),
        .i_issue_dst      (bus.issue_dst),
        .i_issue_long     (bus.issue_long),
        .i_starve_stall   (w_starve_stall),
        .i_commit         (w_buf_commit),
        .i_commit_reg     (r_buf.addr),
        .o_issue_stall    (w_issue_stall),
        .o_commit_pending (w_commit_pending)
    );

endmodule
